// File: rtl/keypad_matrix_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_matrix_scanner_if
//   Key-press event channel between the keypad scanner (master) and whatever
//   consumes key codes (slave: UI FSM, FIFO, ...). An event moves across the
//   channel in every cycle where keyValid && keyReady.
//
//   Signals
//     keyValid  master -> slave  a key-press event is waiting
//     keyCode   master -> slave  code of that event (row*NUM_COLS + col)
//     keyReady  slave  -> master consumer takes the event this cycle
//
//   KEY_W must match the scanner's key code width,
//   max(1, $clog2(NUM_ROWS*NUM_COLS)).
// ---------------------------------------------------------------------------
interface keypad_matrix_scanner_if #(
    parameter int KEY_W = 4
) ();

    logic             keyValid;
    logic             keyReady;
    logic [KEY_W-1:0] keyCode;

    modport master (
        output keyValid,
        output keyCode,
        input  keyReady
    );

    modport slave (
        input  keyValid,
        input  keyCode,
        output keyReady
    );

endinterface

// File: rtl/keypad_matrix_scanner.sv
// ---------------------------------------------------------------------------
// keypad_matrix_scanner
//   Row/column keypad scanner. One column is driven high at a time. The
//   pull-down row inputs are sampled at the end of each column dwell. Each full
//   scan is reduced to NONE / KEY(code) / MULTI. That result is debounced over
//   consecutive scans, and each debounced single-key press produces one event
//   on a valid/ready channel.
//
//   Parameters
//     NUM_ROWS        row inputs (>=1)
//     NUM_COLS        column outputs (>=2)
//     SCAN_DIV        clock cycles each column is driven (>=2)
//     DEBOUNCE_SCANS  identical consecutive scan results needed to accept a change (>=1)
//
//   Ports
//     clock         system clock, everything on posedge
//     reset         synchronous, active-high; clears all state
//     activeRow     row levels, 1 = row connected to the driven column
//     activeColumn  one-hot column drive
//     keyPressed    debounced: exactly one key held
//     multiKey      debounced: two or more keys held
//     overflow      one-cycle pulse: a new event was dropped because the
//                   previous one was still pending
//     evt           event channel (keyValid / keyReady / keyCode), master side
//
//   activeRow is sampled directly. If the pins are asynchronous to clock, they
//   must be synchronised before they reach this block.
// ---------------------------------------------------------------------------
module keypad_matrix_scanner #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 3,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_ROWS-1:0]     activeRow,
    output logic [NUM_COLS-1:0]     activeColumn,
    output logic                    keyPressed,
    output logic                    multiKey,
    output logic                    overflow,
    keypad_matrix_scanner_if.master evt
);

    localparam int KEY_W_RAW = $clog2(NUM_ROWS * NUM_COLS);
    localparam int KEY_W     = (KEY_W_RAW < 1) ? 1 : KEY_W_RAW;
    localparam int ROW_W_RAW = $clog2(NUM_ROWS);
    localparam int ROW_W     = (ROW_W_RAW < 1) ? 1 : ROW_W_RAW;
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int DIV_W     = $clog2(SCAN_DIV);
    localparam int CNT_W     = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0]    r_dwell;
    logic [COL_W-1:0]    r_col;
    logic [NUM_COLS-1:0] r_col_oh;
    logic [1:0]          r_hits;        // hits so far in this scan, saturates at 2
    logic [KEY_W-1:0]    r_first_code;  // code of the first hit in this scan

    res_t                r_cand_kind;
    logic [KEY_W-1:0]    r_cand_code;
    logic [CNT_W-1:0]    r_cnt;

    state_t              r_state;
    logic [KEY_W-1:0]    r_cur_code;

    logic                r_key_valid;
    logic [KEY_W-1:0]    r_key_code;
    logic                r_ovf;

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    logic                w_sample;
    logic                w_last;
    logic [1:0]          w_col_hits;
    logic [ROW_W-1:0]    w_col_row;
    logic [KEY_W-1:0]    w_hit_code;
    logic [2:0]          w_sum;
    logic [1:0]          w_tot;
    logic [KEY_W-1:0]    w_first;
    res_t                w_res_kind;
    logic [KEY_W-1:0]    w_res_code;
    logic                w_same;
    logic                w_accept;
    state_t              w_state_nxt;
    logic [KEY_W-1:0]    w_cur_nxt;
    logic                w_emit;
    logic                w_xfer;

    // ---------------------------------------------------------------------
    // Column scan timing
    // ---------------------------------------------------------------------
    assign w_sample = (r_dwell == DIV_W'(SCAN_DIV - 1));
    assign w_last   = w_sample && (r_col == COL_W'(NUM_COLS - 1));

    // Reduce the rows seen on the driven column to a saturating hit count
    // and the lowest row index that is high.
    always_comb begin
        w_col_hits = 2'd0;
        w_col_row  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (activeRow[r]) begin
                if (w_col_hits == 2'd0) begin
                    w_col_row = ROW_W'(r);
                end
                if (w_col_hits != 2'd2) begin
                    w_col_hits = w_col_hits + 2'd1;
                end
            end
        end
    end

    assign w_hit_code = KEY_W'(int'(w_col_row) * NUM_COLS + int'(r_col));

    // Fold this column into the per-scan accumulators.
    assign w_sum   = {1'b0, r_hits} + {1'b0, w_col_hits};
    assign w_tot   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_first = (r_hits == 2'd0) ? w_hit_code : r_first_code;

    // Scan result. It is meaningful only when w_last is high. The code is
    // forced to 0 for NONE and MULTI so that a plain equality compare works
    // for debouncing.
    always_comb begin
        w_res_kind = RES_NONE;
        w_res_code = '0;
        if (w_tot == 2'd1) begin
            w_res_kind = RES_KEY;
            w_res_code = w_first;
        end else if (w_tot == 2'd2) begin
            w_res_kind = RES_MULTI;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell      <= '0;
            r_col        <= '0;
            r_col_oh     <= NUM_COLS'(1);
            r_hits       <= 2'd0;
            r_first_code <= '0;
        end else if (w_sample) begin
            r_dwell  <= '0;
            r_col_oh <= {r_col_oh[NUM_COLS-2:0], r_col_oh[NUM_COLS-1]};
            if (w_last) begin
                r_col        <= '0;
                r_hits       <= 2'd0;
                r_first_code <= '0;
            end else begin
                r_col        <= r_col + COL_W'(1);
                r_hits       <= w_tot;
                r_first_code <= w_first;
            end
        end else begin
            r_dwell <= r_dwell + DIV_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Debounce: count consecutive identical scan results
    // ---------------------------------------------------------------------
    // Acceptance fires only on the scan where the count reaches
    // DEBOUNCE_SCANS. A saturated count stays there and does not re-accept.
    // With DEBOUNCE_SCANS == 1, every change of result is accepted at once.
    assign w_same   = (w_res_kind == r_cand_kind) && (w_res_code == r_cand_code);
    assign w_accept = w_last &&
                      (w_same ? (r_cnt == CNT_W'(DEBOUNCE_SCANS - 1))
                              : (DEBOUNCE_SCANS == 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cand_kind <= RES_NONE;
            r_cand_code <= '0;
            r_cnt       <= '0;
        end else if (w_last) begin
            if (w_same) begin
                if (r_cnt != CNT_W'(DEBOUNCE_SCANS)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cand_kind <= w_res_kind;
                r_cand_code <= w_res_code;
                r_cnt       <= CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Debounced key state
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_code <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_code <= w_cur_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_code;
        w_emit      = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_res_kind == RES_KEY) begin
                        w_state_nxt = ST_PRESSED;
                        w_cur_nxt   = w_res_code;
                        w_emit      = 1'b1;
                    end else if (w_res_kind == RES_MULTI) begin
                        w_state_nxt = ST_BLOCKED;
                    end
                end
                ST_PRESSED: begin
                    if (w_res_kind == RES_NONE) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_res_kind == RES_MULTI) begin
                        w_state_nxt = ST_BLOCKED;
                    end else if (w_res_code != r_cur_code) begin
                        // Rolled directly from one key to another.
                        w_cur_nxt = w_res_code;
                        w_emit    = 1'b1;
                    end
                end
                ST_BLOCKED: begin
                    // Stay blocked until a full release. Single keys seen
                    // while leaving a chord produce no event.
                    if (w_res_kind == RES_NONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // One-entry event register
    // ---------------------------------------------------------------------
    assign w_xfer = r_key_valid && evt.keyReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_emit) begin
                // The slot is free, or it is being emptied this same cycle.
                if (!r_key_valid || w_xfer) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_res_code;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_xfer) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign activeColumn = r_col_oh;
    assign keyPressed   = (r_state == ST_PRESSED);
    assign multiKey     = (r_state == ST_BLOCKED);
    assign overflow     = r_ovf;
    assign evt.keyValid = r_key_valid;
    assign evt.keyCode  = r_key_code;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//   Directed test of keypad_matrix_scanner with 4 rows, 3 columns, a 4-cycle
//   dwell and 3-scan debounce. A full scan is 12 cycles. The scan's final
//   column is sampled on posedges 12, 24, 36, ... after reset is released.
//   A 12-bit key mask models the keypad: bit r*3+c closes row r to column c.
// ---------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  activeRow;
    logic [2:0]  activeColumn;
    logic        keyPressed;
    logic        multiKey;
    logic        overflow;
    logic [11:0] keys;

    int total;
    int bad;
    int cyc;
    int vld_seen;
    int ovf_seen;

    keypad_matrix_scanner_if #(.KEY_W(4)) evt_if ();

    keypad_matrix_scanner #(
        .NUM_ROWS       (4),
        .NUM_COLS       (3),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .activeRow    (activeRow),
        .activeColumn (activeColumn),
        .keyPressed   (keyPressed),
        .multiKey     (multiKey),
        .overflow     (overflow),
        .evt          (evt_if)
    );

    always #5 clock = ~clock;

    // Keypad physics: a row reads high when a held key connects it to the
    // column currently being driven.
    always_comb begin
        activeRow = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[r*3+c] && activeColumn[c]) begin
                    activeRow[r] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Everything is observed and driven at the negedge.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (evt_if.keyValid) vld_seen++;
        if (overflow) ovf_seen++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Hold reset for n posedges. cyc = 0 afterwards, at the negedge where
    // reset drops.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset    = 1'b0;
        cyc      = 0;
        vld_seen = 0;
        ovf_seen = 0;
    endtask

    initial begin
        clock           = 1'b0;
        reset           = 1'b1;
        keys            = 12'd0;
        evt_if.keyReady = 1'b1;
        total           = 0;
        bad             = 0;
        cyc             = 0;
        vld_seen        = 0;
        ovf_seen        = 0;

        // ---- reset state and column rotation ----
        do_reset(3);
        check("rst_col",      activeColumn,    3'b001);
        check("rst_valid",    evt_if.keyValid, 1'b0);
        check("rst_code",     evt_if.keyCode,  4'd0);
        check("rst_pressed",  keyPressed,      1'b0);
        check("rst_multi",    multiKey,        1'b0);
        check("rst_overflow", overflow,        1'b0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("scan_col", activeColumn, 32'(1) << ((k / 4) % 3));
        end
        check("idle_valid", vld_seen, 0);
        check("idle_multi", multiKey, 1'b0);

        // ---- single key 7 (row 2, col 1) held 5 scans, then released ----
        do_reset(1);
        keys = 12'b1 << 7;
        run_to(35);
        check("k7_early_valid", evt_if.keyValid, 1'b0);
        check("k7_early_press", keyPressed,      1'b0);
        tick();
        check("k7_valid",   evt_if.keyValid, 1'b1);
        check("k7_code",    evt_if.keyCode,  4'd7);
        check("k7_pressed", keyPressed,      1'b1);
        tick();
        check("k7_taken", evt_if.keyValid, 1'b0);
        run_to(60);
        keys = 12'd0;
        run_to(95);
        check("k7_still_pressed", keyPressed, 1'b1);
        tick();
        check("k7_released",   keyPressed,     1'b0);
        check("k7_code_hold",  evt_if.keyCode, 4'd7);
        check("k7_event_count", vld_seen,      1);

        // ---- key 7 present on alternate scans only ----
        do_reset(1);
        keys = 12'b1 << 7;
        run_to(12);
        keys = 12'd0;
        run_to(24);
        keys = 12'b1 << 7;
        run_to(36);
        keys = 12'd0;
        run_to(37);
        check("alt_pressed_a", keyPressed, 1'b0);
        run_to(48);
        keys = 12'b1 << 7;
        run_to(60);
        keys = 12'd0;
        run_to(61);
        check("alt_pressed_b", keyPressed, 1'b0);
        run_to(72);
        check("alt_events", vld_seen, 0);
        check("alt_multi",  multiKey, 1'b0);

        // ---- keys 0 and 5 together for 4 scans, then released ----
        do_reset(1);
        keys = (12'b1 << 0) | (12'b1 << 5);
        run_to(35);
        check("mk_early", multiKey, 1'b0);
        tick();
        check("mk_multi",   multiKey,   1'b1);
        check("mk_pressed", keyPressed, 1'b0);
        run_to(48);
        keys = 12'd0;
        run_to(83);
        check("mk_still_multi", multiKey, 1'b1);
        tick();
        check("mk_released", multiKey, 1'b0);
        check("mk_events",   vld_seen, 0);

        // ---- keyReady low: key 5 event, then key 9 is dropped ----
        do_reset(1);
        evt_if.keyReady = 1'b0;
        keys = 12'b1 << 5;
        run_to(36);
        check("ov_valid5", evt_if.keyValid, 1'b1);
        check("ov_code5",  evt_if.keyCode,  4'd5);
        keys = 12'b1 << 9;
        run_to(71);
        check("ov_no_early", overflow, 1'b0);
        tick();
        check("ov_pulse",   overflow,        1'b1);
        check("ov_valid",   evt_if.keyValid, 1'b1);
        check("ov_code",    evt_if.keyCode,  4'd5);
        check("ov_pressed", keyPressed,      1'b1);
        tick();
        check("ov_pulse_end", overflow, 1'b0);
        check("ov_count",     ovf_seen, 1);
        evt_if.keyReady = 1'b1;
        tick();
        check("ov_drained",   evt_if.keyValid, 1'b0);
        check("ov_code_hold", evt_if.keyCode,  4'd5);
        keys = 12'd0;

        // ---- reset while key 4 (row 1, col 1) is pressed ----
        do_reset(1);
        keys = 12'b1 << 4;
        run_to(40);
        check("rp_pressed", keyPressed, 1'b1);
        do_reset(1);
        check("rp_rst_pressed", keyPressed,      1'b0);
        check("rp_rst_valid",   evt_if.keyValid, 1'b0);
        check("rp_rst_code",    evt_if.keyCode,  4'd0);
        check("rp_rst_multi",   multiKey,        1'b0);
        check("rp_rst_col",     activeColumn,    3'b001);
        run_to(35);
        check("rp_early_valid", evt_if.keyValid, 1'b0);
        tick();
        check("rp_valid",   evt_if.keyValid, 1'b1);
        check("rp_code",    evt_if.keyCode,  4'd4);
        check("rp_pressed2", keyPressed,     1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
